// File: rtl/bus_pkg.sv
// Shared types for the serial-bus RAM slave port: FSM states and transfer-mode encodings.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        RREQ,
        RWAIT,
        RDATA
    } state_e;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first serial shift register with parallel load and a last-bit flag.
module serial_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    input  logic             i_shift_in,
    input  logic             i_bit,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift_out,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_data_nxt,
    output logic             o_bit,
    output logic             o_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_shift;

    assign w_shift    = i_shift_in | i_shift_out;
    // Shift-in and shift-out both move right; shift-out back-fills zeros.
    assign o_data_nxt = {i_shift_in & i_bit, r_data[WIDTH-1:1]};
    assign o_done     = w_shift && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_data     = r_data;
    assign o_bit      = r_data[0];

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_data <= o_data_nxt;
            r_cnt  <= o_done ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_slave_ram_port.sv
// Serial system-bus slave that deserialises address/write data, drives a single-port RAM
// (port A) and returns registered read data bit-serially.
module bus_slave_ram_port #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m_valid,
    input  logic              m_mode,
    input  logic              m_wdata,
    input  logic              m_wvalid,
    output logic              s_ready,
    output logic              s_rdata,
    output logic              s_rvalid,
    output logic              s_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q
);

    import bus_pkg::*;

    localparam int unsigned CNT_W = $clog2(max_u(ADDR_W, DATA_W)) + 1;

    state_e           r_state;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_rvalid;
    logic             r_done;
    logic             r_wren;
    logic             r_rden;

    logic              w_accept;
    logic              w_addr_shift;
    logic              w_wd_shift;
    logic              w_rd_shift;
    logic              w_rd_load;
    logic              w_addr_done;
    logic              w_wd_done;
    logic              w_rd_done;
    logic              w_rd_bit;
    logic              w_in_range;
    logic              w_nxt_in_range;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rd_load_data;
    logic [DATA_W-1:0] w_unused_wd_nxt;
    logic [DATA_W-1:0] w_unused_rd_data;
    logic [DATA_W-1:0] w_unused_rd_nxt;
    logic              w_unused_addr_bit;
    logic              w_unused_wd_bit;

    assign w_accept     = (r_state == IDLE) && m_valid;
    assign w_addr_shift = (r_state == ADDR) && m_wvalid;
    assign w_wd_shift   = (r_state == WDATA) && m_wvalid;
    assign w_rd_shift   = (r_state == RDATA);
    assign w_rd_load    = (r_state == RWAIT) && (r_cnt == CNT_W'(RD_LAT - 1));

    // The last address bit lands in the register at the same edge the read strobe is set.
    assign w_in_range     = (32'(w_addr) < MEM_WORDS);
    assign w_nxt_in_range = (32'(w_addr_nxt) < MEM_WORDS);
    assign w_rd_load_data = w_in_range ? ram_q : '0;

    serial_shift_reg #(.WIDTH(ADDR_W)) u_addr_sr (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_clr       (w_accept),
        .i_shift_in  (w_addr_shift),
        .i_bit       (m_wdata),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift_out (1'b0),
        .o_data      (w_addr),
        .o_data_nxt  (w_addr_nxt),
        .o_bit       (w_unused_addr_bit),
        .o_done      (w_addr_done)
    );

    serial_shift_reg #(.WIDTH(DATA_W)) u_wdata_sr (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_clr       (w_accept),
        .i_shift_in  (w_wd_shift),
        .i_bit       (m_wdata),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift_out (1'b0),
        .o_data      (w_wdata),
        .o_data_nxt  (w_unused_wd_nxt),
        .o_bit       (w_unused_wd_bit),
        .o_done      (w_wd_done)
    );

    serial_shift_reg #(.WIDTH(DATA_W)) u_rdata_sr (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_clr       (1'b0),
        .i_shift_in  (1'b0),
        .i_bit       (1'b0),
        .i_load      (w_rd_load),
        .i_load_data (w_rd_load_data),
        .i_shift_out (w_rd_shift),
        .o_data      (w_unused_rd_data),
        .o_data_nxt  (w_unused_rd_nxt),
        .o_bit       (w_rd_bit),
        .o_done      (w_rd_done)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_mode   <= MODE_READ;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            r_wren   <= 1'b0;
            r_rden   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wren <= 1'b0;
            r_rden <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (m_valid) begin
                        r_mode  <= m_mode;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_wvalid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_addr_done) begin
                            r_cnt <= '0;
                            if (r_mode == MODE_WRITE) begin
                                r_state <= WDATA;
                            end else begin
                                r_state <= RREQ;
                                r_rden  <= w_nxt_in_range;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (m_wvalid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_wd_done) begin
                            r_cnt   <= '0;
                            r_wren  <= w_in_range;
                            r_done  <= 1'b1;
                            r_state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                RREQ: begin
                    r_cnt   <= '0;
                    r_state <= RWAIT;
                end
                RWAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_rd_load) begin
                        r_cnt    <= '0;
                        r_rvalid <= 1'b1;
                        r_state  <= RDATA;
                    end
                end
                RDATA: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_done <= (r_cnt == CNT_W'(DATA_W - 2));
                    if (w_rd_done) begin
                        r_cnt    <= '0;
                        r_rvalid <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready     = r_ready;
    assign s_rvalid    = r_rvalid;
    assign s_done      = r_done;
    assign s_rdata     = w_rd_bit;
    assign ram_address = w_addr;
    assign ram_data    = w_wdata;
    assign ram_wren    = r_wren;
    assign ram_rden    = r_rden;

endmodule

// File: tb/tb_bus_slave_ram_port.sv
// Directed bench for bus_slave_ram_port with a registered RAM model (MEM_WORDS=2048, RD_LAT=1).
module tb_bus_slave_ram_port;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MEM_WORDS = 2048;
    localparam int unsigned RD_LAT    = 1;

    logic              clk      = 1'b0;
    logic              rstn     = 1'b0;
    logic              m_valid  = 1'b0;
    logic              m_mode   = 1'b0;
    logic              m_wdata  = 1'b0;
    logic              m_wvalid = 1'b0;
    logic              s_ready;
    logic              s_rdata;
    logic              s_rvalid;
    logic              s_done;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_q    = '0;

    logic [7:0] mem [0:4095];
    int cyc       = 0;
    int n_checks  = 0;
    int n_fail    = 0;
    int wren_cnt  = 0;
    int rden_cnt  = 0;
    int both_cnt  = 0;
    int start_cyc = 0;

    bus_slave_ram_port #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .m_valid     (m_valid),
        .m_mode      (m_mode),
        .m_wdata     (m_wdata),
        .m_wvalid    (m_wvalid),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .s_rvalid    (s_rvalid),
        .s_done      (s_done),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_rden    (ram_rden),
        .ram_q       (ram_q)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle registered read, write-first not needed since strobes are exclusive.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_rden) begin
            ram_q    <= mem[ram_address];
            rden_cnt <= rden_cnt + 1;
        end
        if (ram_wren) begin
            mem[ram_address] = ram_data;
            wren_cnt <= wren_cnt + 1;
        end
        if (ram_wren && ram_rden) both_cnt <= both_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic mode);
        m_valid   = 1'b1;
        m_mode    = mode;
        start_cyc = cyc;
        tick();
        m_valid   = 1'b0;
        m_mode    = 1'b0;
    endtask

    // Stall cycles drive the inverted bit so a slave that shifts while stalled gets it wrong.
    task automatic send_bits(input logic [11:0] v, input int n, input int stall_at,
                             input int stall_len);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                m_wvalid = 1'b0;
                m_wdata  = ~v[i];
                repeat (stall_len) tick();
            end
            m_wvalid = 1'b1;
            m_wdata  = v[i];
            tick();
        end
        m_wvalid = 1'b0;
        m_wdata  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (s_done) begin
                lat = cyc - start_cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input int stall_at,
                            input int stall_len, output int lat, output logic we,
                            output logic [11:0] wa, output logic [7:0] wd);
        start(1'b1);
        send_bits(a, 12, stall_at, stall_len);
        send_bits({4'h0, d}, 8, -1, 0);
        wait_done(lat);
        we = ram_wren;
        wa = ram_address;
        wd = ram_data;
    endtask

    task automatic do_read(input logic [11:0] a, input int poke_at, output logic [7:0] d,
                           output int lat, output int nb, output int span);
        int first;
        int last;
        logic poked;
        first = -1;
        last  = -1;
        poked = 1'b0;
        d     = '0;
        nb    = 0;
        lat   = -1;
        start(1'b0);
        send_bits(a, 12, -1, 0);
        for (int k = 0; k < 40; k++) begin
            if (s_rvalid) begin
                if (nb < 8) d[nb] = s_rdata;
                if (first < 0) first = cyc;
                last = cyc;
                nb++;
            end
            if (s_done) begin
                lat = cyc - start_cyc;
                break;
            end
            if (poke_at >= 0 && nb == poke_at && !poked) begin
                poked   = 1'b1;
                m_valid = 1'b1;
                m_mode  = 1'b1;
                check("ready_low_in_rdata", 32'(s_ready), 32'd0);
            end else begin
                m_valid = 1'b0;
                m_mode  = 1'b0;
            end
            tick();
        end
        m_valid = 1'b0;
        m_mode  = 1'b0;
        span = last - first + 1;
    endtask

    initial begin
        logic [7:0]  d;
        logic [11:0] wa;
        logic [7:0]  wd;
        logic        we;
        int          lat;
        int          nb;
        int          span;
        int          w0;
        int          r0;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h900] = 8'hFF;

        rstn = 1'b0;
        repeat (3) tick();
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_done", 32'(s_done), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rdata", 32'(s_rdata), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_rden", 32'(ram_rden), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_data", 32'(ram_data), 32'd0);
        rstn = 1'b1;
        tick();

        // Write 0xA5 to 0x012: 1+12+8+1 = 22 cycles inclusive of the m_valid cycle.
        do_write(12'h012, 8'hA5, -1, 0, lat, we, wa, wd);
        check("wr1_latency", 32'(lat), 32'd21);
        check("wr1_wren", 32'(we), 32'd1);
        check("wr1_addr", 32'(wa), 32'h012);
        check("wr1_data", 32'(wd), 32'hA5);
        tick();
        check("wr1_wren_pulse", 32'(ram_wren), 32'd0);
        check("wr1_done_pulse", 32'(s_done), 32'd0);
        check("wr1_ready_after", 32'(s_ready), 32'd1);
        check("wr1_wren_count", 32'(wren_cnt), 32'd1);

        // Read 0x012: 1+12+1+1+8 = 23 cycles inclusive.
        r0 = rden_cnt;
        do_read(12'h012, -1, d, lat, nb, span);
        check("rd1_data", 32'(d), 32'hA5);
        check("rd1_bits", 32'(nb), 32'd8);
        check("rd1_latency", 32'(lat), 32'd22);
        check("rd1_contiguous", 32'(span), 32'd8);
        tick();
        check("rd1_rden_count", 32'(rden_cnt - r0), 32'd1);

        // Write 0x3C to 0x7FF with a 5-cycle stall before address bit 6.
        do_write(12'h7FF, 8'h3C, 6, 5, lat, we, wa, wd);
        check("stall_latency", 32'(lat), 32'd26);
        check("stall_wren", 32'(we), 32'd1);
        check("stall_addr", 32'(wa), 32'h7FF);
        check("stall_data", 32'(wd), 32'h3C);
        tick();
        do_read(12'h7FF, -1, d, lat, nb, span);
        check("stall_readback", 32'(d), 32'h3C);
        tick();

        // Out-of-range address for a 2048-word RAM.
        w0 = wren_cnt;
        do_write(12'h900, 8'h5A, -1, 0, lat, we, wa, wd);
        check("oor_wr_latency", 32'(lat), 32'd21);
        check("oor_wr_wren", 32'(we), 32'd0);
        tick();
        check("oor_wr_count", 32'(wren_cnt - w0), 32'd0);
        r0 = rden_cnt;
        do_read(12'h900, -1, d, lat, nb, span);
        check("oor_rd_data", 32'(d), 32'h00);
        check("oor_rd_bits", 32'(nb), 32'd8);
        check("oor_rd_latency", 32'(lat), 32'd22);
        tick();
        check("oor_rd_rden_count", 32'(rden_cnt - r0), 32'd0);

        // Reset asserted while write-data bit 4 is on the bus.
        w0 = wren_cnt;
        start(1'b1);
        send_bits(12'h012, 12, -1, 0);
        send_bits(12'h077, 4, -1, 0);
        m_wvalid = 1'b1;
        m_wdata  = 1'b1;
        rstn     = 1'b0;
        tick();
        m_wvalid = 1'b0;
        m_wdata  = 1'b0;
        check("abort_ready", 32'(s_ready), 32'd1);
        check("abort_done", 32'(s_done), 32'd0);
        check("abort_rvalid", 32'(s_rvalid), 32'd0);
        check("abort_wren", 32'(ram_wren), 32'd0);
        check("abort_addr", 32'(ram_address), 32'd0);
        check("abort_data", 32'(ram_data), 32'd0);
        rstn = 1'b1;
        repeat (12) tick();
        check("abort_wren_count", 32'(wren_cnt - w0), 32'd0);
        do_read(12'h012, -1, d, lat, nb, span);
        check("abort_old_contents", 32'(d), 32'hA5);
        tick();

        // m_valid during RDATA is ignored; next request accepted right after s_done.
        do_read(12'h7FF, 3, d, lat, nb, span);
        check("poke_rd_data", 32'(d), 32'h3C);
        check("poke_rd_latency", 32'(lat), 32'd22);
        tick();
        check("b2b_ready", 32'(s_ready), 32'd1);
        do_write(12'h055, 8'h11, -1, 0, lat, we, wa, wd);
        check("b2b_latency", 32'(lat), 32'd21);
        check("b2b_wren", 32'(we), 32'd1);
        check("b2b_addr", 32'(wa), 32'h055);
        check("b2b_data", 32'(wd), 32'h11);
        tick();
        check("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
